// File: rtl/spi_master_param.sv
// spi_master_param
//   SPI master with configurable word width, SCK divider, runtime CPOL/CPHA,
//   MISO capture, one-hot active-low chip selects and programmable CS
//   setup/hold. One request is accepted per transfer through a valid/ready
//   handshake that is open only while idle.
//
// Ports
//   clk_100   system clock
//   s_rst     synchronous active-high reset
//   tx_valid  transfer request
//   tx_ready  high only in IDLE; request accepted when tx_valid & tx_ready
//   tx_data   word to transmit
//   cs_sel    target chip select (out-of-range value runs with no CS asserted)
//   cpol      clock polarity for this transfer
//   cpha      clock phase for this transfer
//   rx_data   last received word
//   rx_valid  one-cycle pulse when rx_data is updated
//   busy      high in every state except IDLE
//   SCK       serial clock
//   CS        active-low chip selects
//   MOSI      serial data out
//   MISO      serial data in (already synchronised)
module spi_master_param #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int MSB_FIRST = 1,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_100,
    input  logic              s_rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCK,
    output logic [NUM_CS-1:0] CS,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int TMR_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int EDGES   = 2 * DATA_W;
    localparam int EDGE_W  = $clog2(EDGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [TMR_W-1:0]  tmr;
    logic [EDGE_W-1:0] edge_cnt;
    logic              cpol_q, cpha_q;
    logic [CS_W-1:0]   cs_q;
    logic [DATA_W-1:0] tx_shift, rx_shift, rx_shift_nxt;
    logic              toggle, leading, last_edge, sample_now, advance_now;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Toggle k (1-based) is leading when k is odd, i.e. when the count of
    // toggles already made is even.
    assign toggle      = (state == ST_SHIFT) && (tmr == TMR_W'(CLK_DIV - 1));
    assign leading     = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == EDGE_W'(EDGES - 1));
    assign sample_now  = toggle && (cpha_q ? !leading : leading);
    // With CPHA=0 the first bit is already on MOSI from SETUP, so the final
    // trailing edge has nothing left to present.
    assign advance_now = toggle && (cpha_q ? leading : (!leading && !last_edge));

    always_comb begin
        rx_shift_nxt = rx_shift;
        if (sample_now) begin
            rx_shift_nxt = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], MISO}
                                            : {MISO, rx_shift[DATA_W-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk_100) begin
        if (s_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (tx_valid && tx_ready)            state_nxt = ST_SETUP;
            ST_SETUP: if (tmr == TMR_W'(CS_SETUP - 1))     state_nxt = ST_SHIFT;
            ST_SHIFT: if (toggle && last_edge)             state_nxt = ST_HOLD;
            ST_HOLD:  if (tmr == TMR_W'(CS_HOLD - 1))      state_nxt = ST_IDLE;
            default:                                       state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        tx_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        CS       = '1;
        if (state != ST_IDLE) begin
            for (int unsigned i = 0; i < NUM_CS; i++) begin
                if (cs_q == CS_W'(i)) CS[i] = 1'b0;
            end
        end
    end

    // Datapath: timers, latched request, shift registers, serial pins
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            tmr      <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            cs_q     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if ((state_nxt != state) || toggle) tmr <= '0;
            else if (state != ST_IDLE)          tmr <= tmr + TMR_W'(1);

            unique case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        cs_q     <= cs_sel;
                        SCK      <= cpol;
                        edge_cnt <= '0;
                        if (!cpha) begin
                            MOSI     <= head_bit(tx_data);
                            tx_shift <= drop_head(tx_data);
                        end else begin
                            tx_shift <= tx_data;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (toggle) begin
                        SCK      <= ~SCK;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        rx_shift <= rx_shift_nxt;
                        if (advance_now) begin
                            MOSI     <= head_bit(tx_shift);
                            tx_shift <= drop_head(tx_shift);
                        end
                        // Last bit may be sampled on this very edge, so publish
                        // the post-sample word as HOLD begins.
                        if (last_edge) begin
                            rx_data  <= rx_shift_nxt;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] slave;
        logic        cpol;
        logic        cpha;
        int          cs;
    } xfer_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int DW   = (g == 0) ? 16 : 8;
        localparam int CD   = (g == 0) ? 4 : 1;
        localparam int NCS  = (g == 0) ? 4 : 3;
        localparam int SU   = 2;
        localparam int HO   = 2;
        localparam int MSBF = (g == 0) ? 1 : 0;
        localparam int CSW  = $clog2(NCS);
        localparam int BLEN = SU + 2 * DW * CD + HO;
        localparam int RST_AT = (2 * DW * CD > 80) ? 40 : DW;

        logic            s_rst = 1'b1, tx_valid = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
        logic [DW-1:0]   tx_data = '0;
        logic [CSW-1:0]  cs_sel = '0;
        logic            tx_ready, rx_valid, busy, sck, mosi;
        logic [DW-1:0]   rx_data;
        logic [NCS-1:0]  cs;
        bit              done = 0;

        spi_master_param #(
            .DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NCS),
            .CS_SETUP(SU), .CS_HOLD(HO), .MSB_FIRST(MSBF)
        ) dut (
            .clk_100(clk), .s_rst(s_rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
            .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
            .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .SCK(sck),
            .CS(cs), .MOSI(mosi), .MISO(miso)
        );

        xfer_t q[$];
        int    cyc = 0;
        always @(posedge clk) cyc <= cyc + 1;

        task automatic ck(input string n, input logic [31:0] a, input logic [31:0] e);
            chk($sformatf("cfg%0d %s", g, n), a, e);
        endtask

        // Position in the word of the k-th bit on the wire.
        function automatic int pos(input int k);
            return (MSBF != 0) ? DW - 1 - k : k;
        endfunction

        function automatic logic [NCS-1:0] exp_cs(input int sel);
            logic [NCS-1:0] r = '1;
            for (int i = 0; i < NCS; i++) if (sel == i) r[i] = 1'b0;
            return r;
        endfunction

        // ---------------- monitor / slave model ----------------
        xfer_t         cur;
        bit            active = 0, cs_bad = 0, lead;
        int            blen, tog, rxv, sidx, cap_n;
        logic [DW-1:0] cap;
        logic          prev_sck = 1'b0, prev_mosi = 1'b0, exp_mosi;

        always @(negedge clk) begin
            if (s_rst) begin
                active = 0;
            end else begin
                if (busy && !active) begin
                    ck("queue holds request at start", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        active = 1; blen = 0; tog = 0; rxv = 0; sidx = 0;
                        cap = '0; cap_n = 0; cs_bad = 0; prev_sck = sck;
                        ck("SCK at setup", sck, cur.cpol);
                        exp_mosi = cur.cpha ? prev_mosi : cur.tx[pos(0)];
                        ck("MOSI at setup", mosi, exp_mosi);
                        if (!cur.cpha) begin
                            miso = cur.slave[pos(0)];
                            sidx = 1;
                        end
                    end
                end
                if (active && busy) begin
                    blen++;
                    if (cs !== exp_cs(cur.cs)) cs_bad = 1;
                    if (sck !== prev_sck) begin
                        tog++;
                        lead = (tog % 2) == 1;
                        if (lead != cur.cpha) begin
                            if (cap_n < DW) cap[pos(cap_n)] = mosi;
                            cap_n++;
                        end else if (sidx < DW) begin
                            miso = cur.slave[pos(sidx)];
                            sidx++;
                        end
                        prev_sck = sck;
                    end
                    if (rx_valid) begin
                        rxv++;
                        ck("rx_data", rx_data, cur.slave);
                    end
                end else if (active && !busy) begin
                    ck("busy length", blen, BLEN);
                    ck("SCK toggles", tog, 2 * DW);
                    ck("rx_valid pulses", rxv, 1);
                    ck("CS pattern during transfer", cs_bad, 0);
                    ck("SCK idle level", sck, cur.cpol);
                    ck("slave captured MOSI", cap, cur.tx);
                    ck("CS released", cs, {NCS{1'b1}});
                    active = 0;
                end else if (rx_valid) begin
                    ck("rx_valid outside transfer", rx_valid, 0);
                end
                if (!busy) prev_mosi = mosi;
            end
        end

        // ---------------- driver ----------------
        task automatic tick();
            @(posedge clk);
            #2;
        endtask

        task automatic send(input logic [DW-1:0] tx, input int sel, input logic pol,
                            input logic pha, input logic [DW-1:0] slv, input bit keep,
                            output int acc);
            xfer_t x;
            int k;
            tx_valid = 1'b1;
            tx_data  = tx;
            cs_sel   = CSW'(sel);
            cpol     = pol;
            cpha     = pha;
            for (k = 0; k < 4 * BLEN; k++) begin
                if (tx_ready) break;
                tick();
            end
            if (k == 4 * BLEN) ck("accept timeout", tx_ready, 1);
            x.tx = 16'(tx); x.slave = 16'(slv); x.cpol = pol; x.cpha = pha; x.cs = sel;
            q.push_back(x);
            acc = cyc;
            tick();
            if (!keep) tx_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int k;
            for (k = 0; k < 4 * BLEN; k++) begin
                if (!busy) break;
                tick();
            end
            if (k == 4 * BLEN) ck("idle timeout", busy, 0);
        endtask

        task automatic junk();
            tick();
            tx_valid = 1'b1;
            tx_data  = DW'($urandom);
            cs_sel   = CSW'($urandom);
            cpol     = 1'($urandom);
            cpha     = 1'($urandom);
            tick();
            tx_valid = 1'b0;
        endtask

        task automatic check_reset_values(input string tag);
            @(negedge clk);
            ck({tag, " tx_ready"}, tx_ready, 1);
            ck({tag, " busy"}, busy, 0);
            ck({tag, " rx_valid"}, rx_valid, 0);
            ck({tag, " rx_data"}, rx_data, 0);
            ck({tag, " SCK"}, sck, 0);
            ck({tag, " CS"}, cs, {NCS{1'b1}});
            ck({tag, " MOSI"}, mosi, 0);
        endtask

        initial begin
            int t1, t2, ta;
            repeat (3) tick();
            s_rst = 1'b0;
            check_reset_values("reset");

            // mode 0, loopback-style slave echoes the word
            send(DW'(16'hA5C3), 0, 1'b0, 1'b0, DW'(16'hA5C3), 0, ta);
            wait_idle();
            // mode 3, slave drives all ones
            send(DW'(16'h0001), 2, 1'b1, 1'b1, {DW{1'b1}}, 0, ta);
            wait_idle();
            // back-to-back with tx_valid held
            send(DW'(16'h1234), 1, 1'b0, 1'b0, DW'($urandom), 1, t1);
            send(DW'(16'h5678), 2, 1'b0, 1'b1, DW'($urandom), 0, t2);
            ck("back-to-back accept spacing", t2 - t1, BLEN + 1);
            wait_idle();
            // all-ones cs_sel (out of range for NCS=3) plus ignored requests
            send(DW'($urandom), 3, 1'b1, 1'b0, DW'($urandom), 0, ta);
            junk();
            junk();
            wait_idle();
            // reset part way through SHIFT
            send(DW'($urandom), 0, 1'b0, 1'b0, DW'($urandom), 0, ta);
            repeat (SU + RST_AT) tick();
            s_rst = 1'b1;
            q.delete();
            tick();
            s_rst = 1'b0;
            check_reset_values("mid-transfer reset");
            tick();
            send(DW'(16'hC35A), 1, 1'b0, 1'b1, DW'(16'h3C96), 0, ta);
            wait_idle();
            // randomized transfers
            for (int i = 0; i < 16; i++) begin
                send(DW'($urandom), int'($urandom_range(0, (1 << CSW) - 1)),
                     1'($urandom), 1'($urandom), DW'($urandom), 0, ta);
                if ($urandom_range(0, 1) == 1) junk();
                wait_idle();
                repeat ($urandom_range(0, 2)) tick();
            end
            repeat (4) tick();
            done = 1;
        end
    end

    initial begin
        int i;
        for (i = 0; i < 60000; i++) begin
            if (cfg[0].done && cfg[1].done) break;
            @(posedge clk);
        end
        if (i == 60000) begin
            n_checks++;
            n_fail++;
            $display("FAIL global timeout: got running expected done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
